// File: rtl/floo_pkg.sv
// Shared FlooNoC types for the credit-based VC link transmitter.
// Holds the flit layout, credit counter type and transmitter FSM states.
package floo_pkg;

    localparam int unsigned VCDepthDefault = 2;

    typedef logic [$clog2(VCDepthDefault+1)-1:0] vc_credit_t;

    typedef enum logic [2:0] {
        North,
        East,
        South,
        West,
        Eject,
        NumDirections
    } route_direction_e;

    typedef struct packed {
        logic       last;
        logic [1:0] vc_id;
    } floo_hdr_t;

    typedef struct packed {
        floo_hdr_t   hdr;
        logic [15:0] payload;
    } floo_flit_t;

    typedef enum logic {
        TxIdle,
        TxLocked
    } tx_state_e;

endpackage

// File: rtl/floo_vc_credit_counter.sv
// Saturating per-VC credit counter, reset to the downstream buffer depth.
// Simultaneous inc/dec cancel; an inc at full depth pulses overflow_o.
module floo_vc_credit_counter #(
    parameter int unsigned Depth = 2,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [CntW-1:0] count_o,
    output logic            has_credit_o,
    output logic            overflow_o
);

    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;

    // next count: return adds, send subtracts, full + return saturates
    always_comb begin
        count_d    = count_q;
        overflow_o = 1'b0;
        if (inc_i && !dec_i) begin
            if (count_q == CntW'(Depth)) begin
                overflow_o = 1'b1;
            end else begin
                count_d = count_q + CntW'(1);
            end
        end else if (dec_i && !inc_i) begin
            if (count_q != '0) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    // counter register, full of credit after reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= CntW'(Depth);
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign has_credit_o = (count_q != '0);

endmodule

// File: rtl/floo_vc_credit_tx.sv
// Credit-based VC link transmitter: picks a VC with credit per packet, wormhole-locks it.
// Optional FLOO_VC_TX_FALLBACK_EN: head flit falls back to the lowest VC with credit.
module floo_vc_credit_tx
    import floo_pkg::*;
#(
    parameter int unsigned NumVC      = 4,
    parameter int unsigned NumVCWidth = 2,
    parameter int unsigned VCDepth    = VCDepthDefault,
    parameter type         flit_t     = floo_pkg::floo_flit_t
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  flit_t                 data_i,
    input  logic [NumVCWidth-1:0] pref_vc_i,
    output logic                  data_v_o,
    output flit_t                 data_o,
    output logic [NumVCWidth-1:0] vc_id_o,
    input  logic                  credit_v_i,
    input  logic [NumVCWidth-1:0] credit_id_i,
    output logic                  credit_err_o
);

    localparam int unsigned CntW = $clog2(VCDepth + 1);

    if (NumVCWidth != $clog2(NumVC)) begin : g_bad_width
        $error("NumVCWidth must equal $clog2(NumVC)");
    end

    logic [CntW-1:0]       cnt [NumVC];
    logic [NumVC-1:0]      has_credit;
    logic [NumVC-1:0]      ovf;
    logic [NumVC-1:0]      inc;
    logic [NumVC-1:0]      dec;
    logic [NumVCWidth-1:0] sel_vc;
    logic                  xfer;

    tx_state_e             state_q, state_d;
    logic [NumVCWidth-1:0] lock_q, lock_d;
    logic                  data_v_q, data_v_d;
    flit_t                 data_q, data_d;
    logic [NumVCWidth-1:0] vc_id_q, vc_id_d;
    logic                  credit_err_q, credit_err_d;

    for (genvar i = 0; i < NumVC; i++) begin : g_cnt
        assign inc[i] = credit_v_i && (credit_id_i == NumVCWidth'(i));
        assign dec[i] = xfer && (sel_vc == NumVCWidth'(i));

        floo_vc_credit_counter #(
            .Depth (VCDepth),
            .CntW  (CntW)
        ) u_cnt (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .inc_i        (inc[i]),
            .dec_i        (dec[i]),
            .count_o      (cnt[i]),
            .has_credit_o (has_credit[i]),
            .overflow_o   (ovf[i])
        );
    end

    // VC selection: locked VC mid-packet, preferred (or fallback) VC on a head
    always_comb begin
        sel_vc = pref_vc_i;
        if (state_q == TxLocked) begin
            sel_vc = lock_q;
        end
`ifdef FLOO_VC_TX_FALLBACK_EN
        else if (!has_credit[pref_vc_i]) begin
            for (int i = NumVC - 1; i >= 0; i--) begin
                if (has_credit[i]) begin
                    sel_vc = NumVCWidth'(i);
                end
            end
        end
`endif
    end

    assign ready_o = (cnt[sel_vc] != '0);
    assign xfer    = valid_i && ready_o;

    // next-state: wormhole lock, output capture and sticky credit error
    always_comb begin
        state_d      = state_q;
        lock_d       = lock_q;
        data_v_d     = xfer;
        data_d       = data_q;
        vc_id_d      = vc_id_q;
        credit_err_d = credit_err_q | (|ovf);
        if (xfer) begin
            data_d  = data_i;
            vc_id_d = sel_vc;
            case (state_q)
                TxIdle: begin
                    if (!data_i.hdr.last) begin
                        state_d = TxLocked;
                        lock_d  = sel_vc;
                    end
                end
                TxLocked: begin
                    if (data_i.hdr.last) begin
                        state_d = TxIdle;
                    end
                end
                default: state_d = TxIdle;
            endcase
        end
    end

    // FSM, lock and registered link outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= TxIdle;
            lock_q       <= '0;
            data_v_q     <= 1'b0;
            data_q       <= '0;
            vc_id_q      <= '0;
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_q       <= lock_d;
            data_v_q     <= data_v_d;
            data_q       <= data_d;
            vc_id_q      <= vc_id_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign data_v_o     = data_v_q;
    assign data_o       = data_q;
    assign vc_id_o      = vc_id_q;
    assign credit_err_o = credit_err_q;

endmodule
